// File: rtl/load_unit.sv
// load_unit: data-memory load sequencer. Accepts one load at a time, issues
// one or two word reads, extracts the addressed byte/halfword/word
// little-endian, extends it and holds the response until consumed.
// The byte-size select is named byte_sel because "byte" is a reserved word.
//
// Handshakes: a transfer on either side happens on a posedge where both
// valid and ready are 1; the producer keeps payload stable while valid is
// high, and valid never drops without a transfer (except on reset).
module load_unit #(
    parameter bit SPLIT_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        byte_sel,
    input  logic        halfword,
    input  logic        req_signed,
    output logic        mem_re,
    output logic [29:0] mem_addr,
    input  logic [31:0] mem_rdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_data,
    output logic        resp_err,
    output logic [2:0]  state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RD0   = 3'd1,
        S_WAIT0 = 3'd2,
        S_RD1   = 3'd3,
        S_WAIT1 = 3'd4,
        S_RESP  = 3'd5
    } state_t;

    state_t      state, state_next;
    logic [31:0] addr_q;
    logic [1:0]  size_q;
    logic        signed_q;
    logic [31:0] lo_q, hi_q;
    logic [31:0] resp_data_q;
    logic        resp_err_q;

    // Size encoding {byte_sel, halfword}: 00 word, 01 halfword, 10 byte, 11 illegal.
    function automatic logic crossing(input logic [1:0] sz, input logic [1:0] off);
        logic c;
        c = 1'b0;
        case (sz)
            2'b00:   c = (off != 2'd0);
            2'b01:   c = (off == 2'd3);
            default: c = 1'b0;
        endcase
        return c;
    endfunction

    logic [1:0]  req_size;
    logic        req_bad;
    logic        cross_q;
    logic [31:0] lo_src, hi_src;
    logic [63:0] shifted;
    logic [31:0] ext;

    assign req_size  = {byte_sel, halfword};
    assign req_bad   = (&req_size) | (!SPLIT_EN && crossing(req_size, req_addr[1:0]));
    assign cross_q   = crossing(size_q, addr_q[1:0]);
    assign resp_data = resp_data_q;
    assign resp_err  = resp_err_q;
    assign state_dbg = state;

    // Extraction: the word being returned this cycle bypasses its capture register.
    always_comb begin
        lo_src  = (state == S_WAIT0) ? mem_rdata : lo_q;
        hi_src  = (state == S_WAIT1) ? mem_rdata : hi_q;
        shifted = {hi_src, lo_src} >> {addr_q[1:0], 3'b000};
        case (size_q)
            2'b10:   ext = signed_q ? {{24{shifted[7]}}, shifted[7:0]}
                                    : {24'd0, shifted[7:0]};
            2'b01:   ext = signed_q ? {{16{shifted[15]}}, shifted[15:0]}
                                    : {16'd0, shifted[15:0]};
            default: ext = shifted[31:0];
        endcase
    end

    // State register; reset abandons any request in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_next;
    end

    // Next-state and Moore outputs.
    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        mem_re     = 1'b0;
        resp_valid = 1'b0;
        mem_addr   = addr_q[31:2];
        case (state)
            S_IDLE: begin
                req_ready = rst_n;
                if (req_valid) state_next = req_bad ? S_RESP : S_RD0;
            end
            S_RD0: begin
                mem_re     = 1'b1;
                state_next = S_WAIT0;
            end
            S_WAIT0: state_next = cross_q ? S_RD1 : S_RESP;
            S_RD1: begin
                mem_re     = 1'b1;
                mem_addr   = addr_q[31:2] + 30'd1;
                state_next = S_WAIT1;
            end
            S_WAIT1: state_next = S_RESP;
            S_RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Request latch, read-data capture and response registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_q      <= 32'd0;
            size_q      <= 2'd0;
            signed_q    <= 1'b0;
            lo_q        <= 32'd0;
            hi_q        <= 32'd0;
            resp_data_q <= 32'd0;
            resp_err_q  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        addr_q     <= req_addr;
                        size_q     <= req_size;
                        signed_q   <= req_signed;
                        resp_err_q <= req_bad;
                        if (req_bad) resp_data_q <= 32'd0;
                    end
                end
                S_WAIT0: begin
                    lo_q <= mem_rdata;
                    if (!cross_q) resp_data_q <= ext;
                end
                S_WAIT1: begin
                    hi_q        <= mem_rdata;
                    resp_data_q <= ext;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_load_unit.sv
// tb_load_unit: directed checks of load_unit with SPLIT_EN=1 (u0) and
// SPLIT_EN=0 (u1) against a small data-memory model.
module tb_load_unit;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        req_valid0 = 1'b0, req_valid1 = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic        byte_sel = 1'b0, halfword = 1'b0, req_signed = 1'b0;
    logic        resp_ready = 1'b1;

    logic        req_ready0, req_ready1, mem_re0, mem_re1;
    logic [29:0] mem_addr0, mem_addr1;
    logic [31:0] rdata0 = 32'd0, rdata1 = 32'd0;
    logic        resp_valid0, resp_valid1, resp_err0, resp_err1;
    logic [31:0] resp_data0, resp_data1;
    logic [2:0]  state_dbg0, state_dbg1;

    load_unit #(.SPLIT_EN(1'b1)) u0 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid0), .req_ready(req_ready0),
        .req_addr(req_addr), .byte_sel(byte_sel), .halfword(halfword),
        .req_signed(req_signed), .mem_re(mem_re0), .mem_addr(mem_addr0),
        .mem_rdata(rdata0), .resp_valid(resp_valid0), .resp_ready(resp_ready),
        .resp_data(resp_data0), .resp_err(resp_err0), .state_dbg(state_dbg0)
    );

    load_unit #(.SPLIT_EN(1'b0)) u1 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid1), .req_ready(req_ready1),
        .req_addr(req_addr), .byte_sel(byte_sel), .halfword(halfword),
        .req_signed(req_signed), .mem_re(mem_re1), .mem_addr(mem_addr1),
        .mem_rdata(rdata1), .resp_valid(resp_valid1), .resp_ready(resp_ready),
        .resp_data(resp_data1), .resp_err(resp_err1), .state_dbg(state_dbg1)
    );

    // ---------------- memory model and read monitor ----------------
    function automatic logic [31:0] mem_word(input logic [29:0] a);
        case (a)
            30'h0000_0001: return 32'h8765_43A1;
            30'h0000_0002: return 32'h1122_33F4;
            30'h3FFF_FFFF: return 32'hAABB_CCDD;
            30'h0000_0000: return 32'h0000_0000;
            default:       return 32'h5A5A_0000 ^ {2'b00, a};
        endcase
    endfunction

    logic [29:0] re_addr0[$];
    logic [29:0] re_addr1[$];

    always @(posedge clk) begin
        rdata0 <= mem_re0 ? mem_word(mem_addr0) : 32'hBAD0_BAD0;
        rdata1 <= mem_re1 ? mem_word(mem_addr1) : 32'hBAD1_BAD1;
        if (mem_re0) re_addr0.push_back(mem_addr0);
        if (mem_re1) re_addr1.push_back(mem_addr1);
    end

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // ---------------- driver ----------------
    // Issues one load, waits (bounded) for the response, checks latency,
    // data, error, read pulses; optionally stalls resp_ready for hold cycles.
    task automatic run_load(input string tag, input int inst, input logic [31:0] addr,
                            input logic b, input logic h, input logic s,
                            input logic [31:0] exp_data, input logic exp_err,
                            input int exp_lat, input int exp_nre,
                            input logic [29:0] exp_a0, input logic [29:0] exp_a1,
                            input int hold);
        int n0, n1, lat;
        logic [31:0] held;
        @(negedge clk);
        req_addr   = addr;
        byte_sel   = b;
        halfword   = h;
        req_signed = s;
        resp_ready = (hold == 0);
        n0 = (inst == 1) ? re_addr1.size() : re_addr0.size();
        chk({tag, " req_ready"}, {31'd0, (inst == 1) ? req_ready1 : req_ready0}, 32'd1);
        if (inst == 1) req_valid1 = 1'b1;
        else           req_valid0 = 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            req_valid0 = 1'b0;
            req_valid1 = 1'b0;
        end while (!((inst == 1) ? resp_valid1 : resp_valid0) && lat < 20);
        n1 = (inst == 1) ? re_addr1.size() : re_addr0.size();
        chk({tag, " latency"}, lat, exp_lat);
        chk({tag, " data"}, (inst == 1) ? resp_data1 : resp_data0, exp_data);
        chk({tag, " err"}, {31'd0, (inst == 1) ? resp_err1 : resp_err0}, {31'd0, exp_err});
        chk({tag, " mem_re count"}, n1 - n0, exp_nre);
        if (exp_nre >= 1 && n1 > n0)
            chk({tag, " mem_addr0"}, {2'b00, (inst == 1) ? re_addr1[n0] : re_addr0[n0]},
                {2'b00, exp_a0});
        if (exp_nre >= 2 && n1 > n0 + 1)
            chk({tag, " mem_addr1"}, {2'b00, (inst == 1) ? re_addr1[n0+1] : re_addr0[n0+1]},
                {2'b00, exp_a1});
        held = (inst == 1) ? resp_data1 : resp_data0;
        for (int i = 0; i < hold; i++) begin
            chk({tag, " hold data"}, (inst == 1) ? resp_data1 : resp_data0, held);
            chk({tag, " hold valid"}, {31'd0, (inst == 1) ? resp_valid1 : resp_valid0}, 32'd1);
            chk({tag, " hold req_ready"}, {31'd0, (inst == 1) ? req_ready1 : req_ready0}, 32'd0);
            @(negedge clk);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        chk({tag, " resp dropped"}, {31'd0, (inst == 1) ? resp_valid1 : resp_valid0}, 32'd0);
        chk({tag, " back idle"}, {31'd0, (inst == 1) ? req_ready1 : req_ready0}, 32'd1);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int n0;
        repeat (3) @(negedge clk);
        chk("rst req_ready", {31'd0, req_ready0}, 32'd0);
        chk("rst mem_re", {31'd0, mem_re0}, 32'd0);
        chk("rst mem_addr", {2'b00, mem_addr0}, 32'd0);
        chk("rst resp_valid", {31'd0, resp_valid0}, 32'd0);
        chk("rst resp_data", resp_data0, 32'd0);
        chk("rst resp_err", {31'd0, resp_err0}, 32'd0);
        rst_n = 1'b1;
        #1;
        chk("post-rst req_ready", {31'd0, req_ready0}, 32'd1);

        //        tag           inst addr          b     h     s     data          err  lat nre a0          a1          hold
        run_load("word 0x4",    0, 32'h0000_0004, 1'b0, 1'b0, 1'b0, 32'h8765_43A1, 1'b0, 3, 1, 30'd1,      30'd0,      0);
        run_load("sbyte 0x4",   0, 32'h0000_0004, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFA1, 1'b0, 3, 1, 30'd1,      30'd0,      0);
        run_load("ubyte 0x4",   0, 32'h0000_0004, 1'b1, 1'b0, 1'b0, 32'h0000_00A1, 1'b0, 3, 1, 30'd1,      30'd0,      0);
        run_load("shalf 0x6",   0, 32'h0000_0006, 1'b0, 1'b1, 1'b1, 32'hFFFF_8765, 1'b0, 3, 1, 30'd1,      30'd0,      0);
        run_load("uhalf 0x5",   0, 32'h0000_0005, 1'b0, 1'b1, 1'b0, 32'h0000_6543, 1'b0, 3, 1, 30'd1,      30'd0,      0);
        run_load("sbyte 0x7",   0, 32'h0000_0007, 1'b1, 1'b0, 1'b1, 32'hFFFF_FF87, 1'b0, 3, 1, 30'd1,      30'd0,      0);
        run_load("word 0x7",    0, 32'h0000_0007, 1'b0, 1'b0, 1'b0, 32'h2233_F487, 1'b0, 5, 2, 30'd1,      30'd2,      0);
        run_load("shalf 0x7",   0, 32'h0000_0007, 1'b0, 1'b1, 1'b1, 32'hFFFF_F487, 1'b0, 5, 2, 30'd1,      30'd2,      0);
        run_load("word wrap",   0, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 32'h0000_AABB, 1'b0, 5, 2, 30'h3FFFFFFF, 30'd0,   0);
        run_load("illegal u0",  0, 32'h0000_0004, 1'b1, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1, 0, 30'd0,      30'd0,      0);
        run_load("nosplit 0x7", 1, 32'h0000_0007, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1, 0, 30'd0,      30'd0,      0);
        run_load("illegal u1",  1, 32'h0000_0004, 1'b1, 1'b1, 1'b1, 32'h0000_0000, 1'b1, 1, 0, 30'd0,      30'd0,      0);
        run_load("u1 word 0x8", 1, 32'h0000_0008, 1'b0, 1'b0, 1'b0, 32'h1122_33F4, 1'b0, 3, 1, 30'd2,      30'd0,      0);
        run_load("backpressure",0, 32'h0000_0004, 1'b0, 1'b0, 1'b0, 32'h8765_43A1, 1'b0, 3, 1, 30'd1,      30'd0,      4);

        // Reset while WAIT0: request abandoned, no response ever appears.
        @(negedge clk);
        req_addr   = 32'h0000_0004;
        byte_sel   = 1'b0;
        halfword   = 1'b0;
        req_signed = 1'b0;
        n0 = re_addr0.size();
        req_valid0 = 1'b1;
        @(negedge clk);
        req_valid0 = 1'b0;
        chk("rstw state RD0", {29'd0, state_dbg0}, 32'd1);
        @(negedge clk);
        chk("rstw state WAIT0", {29'd0, state_dbg0}, 32'd2);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rstw state IDLE", {29'd0, state_dbg0}, 32'd0);
        chk("rstw resp_valid", {31'd0, resp_valid0}, 32'd0);
        chk("rstw req_ready low", {31'd0, req_ready0}, 32'd0);
        chk("rstw resp_data", resp_data0, 32'd0);
        rst_n = 1'b1;
        #1;
        chk("rstw req_ready", {31'd0, req_ready0}, 32'd1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("rstw no response", {31'd0, resp_valid0}, 32'd0);
        end
        chk("rstw mem_re count", re_addr0.size() - n0, 32'd1);

        // ---------------- final report ----------------
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
